// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the requester-side valid/ready/data bus and the UART TX control
// bus that the uart_tx_arbiter sits between.
//
// Parameters
//   N_REQ        number of byte producers sharing the UART TX (2..8)
//
// Signals
//   req_valid    [N_REQ]    per-requester byte-available flag
//   req_data     [8*N_REQ]  per-requester byte, requester i in [8i+7:8i]
//   req_ready    [N_REQ]    one-hot accept strobe
//   tx_start     [1]        one-cycle start pulse to the UART TX
//   tx_data      [8]        byte to the UART TX
//   tx_done      [1]        one-cycle completion pulse from the UART TX
//   busy         [1]        arbiter is not idle
//   grant_id     [IDX_W]    index of the last accepted requester
//   err_timeout  [1]        one-cycle pulse on watchdog abort
//
// Modports
//   master       arbiter view (drives ready, TX control and status)
//   slave        environment view (requesters, UART TX and observers)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_done;
    logic               busy;
    logic [IDX_W-1:0]   grant_id;
    logic               err_timeout;

    modport master (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_start, tx_data, busy, grant_id, err_timeout
    );

    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_start, tx_data, busy, grant_id, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ
// byte producers. One byte is in flight at a time: a winner is accepted in
// IDLE, tx_start pulses in START, and the grant is held in WAIT_DONE until
// the UART TX reports tx_done.
//
// Parameters
//   N_REQ        number of requesters (2..8)
//   TIMEOUT_CYC  watchdog limit from tx_start to tx_done (optional feature)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   bus          uart_tx_arbiter_if.master (requester bus + UART TX control)
//
// Optional feature
//   UART_ARB_TIMEOUT_EN  when defined, a watchdog aborts a transfer that has
//                        not completed within TIMEOUT_CYC cycles and pulses
//                        err_timeout. When undefined, no counter is built,
//                        err_timeout is tied low and WAIT_DONE waits forever.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             accept;
    logic             timeout_hit;

    logic [N_REQ-1:0] req_ready;
    logic             tx_start;
    logic             busy;

    // -----------------------------------------------------------------------
    // Round-robin scan. Offsets are walked from farthest to nearest so the
    // requester closest to rr_ptr (in wrap-around order) is written last and
    // therefore wins.
    // -----------------------------------------------------------------------
    always_comb begin : rr_scan
        logic [IDX_W:0] sum;
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch forms.
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            if (bus.req_valid[sum[IDX_W-1:0]]) begin
                winner    = sum[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign accept = (state_q == IDLE) && any_valid;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. tx_done wins over the watchdog because
    // timeout_hit is already qualified with !tx_done.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) state_d = START;
            end
            START: begin
                if (bus.tx_done || timeout_hit) state_d = IDLE;
                else                            state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. req_ready is gated with rst because the scan itself is
    // purely combinational from req_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready[winner] = any_valid && !rst;
            end
            START: begin
                tx_start = 1'b1;
                busy     = 1'b1;
            end
            WAIT_DONE: begin
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Grant datapath: captured on the accepting edge and held until the next
    // acceptance, so tx_data stays stable through the whole transfer.
    // -----------------------------------------------------------------------
    always_comb begin
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            tx_data_d  = bus.req_data[{winner, 3'b000} +: 8];
            grant_id_d = winner;
            rr_ptr_d   = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // -----------------------------------------------------------------------
    // Watchdog: cleared on the accepting edge (so it reads 0 in START) and
    // counts every cycle spent in START/WAIT_DONE. Reaching TIMEOUT_CYC-1
    // without tx_done aborts to IDLE; err_timeout is the registered pulse of
    // that decision, so it appears TIMEOUT_CYC cycles after tx_start.
    // -----------------------------------------------------------------------
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q != IDLE) && !bus.tx_done &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err_d       = timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.req_ready = req_ready;
    assign bus.tx_start  = tx_start;
    assign bus.busy      = busy;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ byte producers.
- Each requester offers a byte with a valid/ready handshake.
- The arbiter picks one winner, drives tx_start/tx_data into the UART TX, and holds the grant until the TX reports tx_done.
- Sits between the packet/command sources and the UART TX core, on the same clk/rst domain.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.
TIMEOUT_CYC, 200000, cycles allowed from tx_start to tx_done before abort; used only with UART_ARB_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  N_REQ  per-requester byte-available flag.
req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
req_ready  output  N_REQ  one-hot accept strobe, combinational from state and req_valid.
tx_start  output  1  one-cycle start pulse to UART TX.
tx_data  output  8  byte to UART TX; stable from tx_start until tx_done.
tx_done  input  1  one-cycle completion pulse from UART TX.
busy  output  1  high whenever not in IDLE.
grant_id  output  clog2(N_REQ)  index of the last accepted requester.
err_timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, tx_start=0, tx_data=0x00, busy=0, grant_id=0, err_timeout=0, rr_ptr=0; req_ready=0 while rst is high.
- FSM states: IDLE, START, WAIT_DONE.
- IDLE, no req_valid bit set: stay in IDLE; all outputs quiescent.
- IDLE, any req_valid bit set:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[winner]=1 in this same cycle; the handshake completes on this clock edge.
  - At the edge: tx_data<=req_data[winner], grant_id<=winner, rr_ptr<=(winner+1) mod N_REQ, state<=START.
- START: tx_start=1 for exactly this one cycle; busy=1; next state WAIT_DONE.
  - If tx_done is high in START, go directly to IDLE instead.
- WAIT_DONE: tx_start=0; tx_data held; busy=1; req_ready all 0.
  - tx_done=1: next state IDLE.
- Latency:
  - req_valid high in IDLE at cycle k → tx_start high at cycle k+1.
  - tx_done at cycle m → IDLE at m+1 → next acceptance possible at m+1.
- Ordering and stalls:
  - At most one byte is in flight. Requesters must hold req_valid/req_data until they see req_ready.
  - A requester dropping req_valid before acceptance is simply skipped.
- Fairness: with all N_REQ valid continuously, grants rotate 0,1,...,N_REQ-1,0; no requester waits more than N_REQ-1 transfers.
- tx_done seen in IDLE is ignored: no state change, no error.
- Reset asserted mid-transfer aborts immediately to reset values. The byte in flight is lost; the UART TX is reset by the same rst.
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
Macro: UART_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to START and increments each cycle in START/WAIT_DONE.
  - If it reaches TIMEOUT_CYC-1 without tx_done: next state IDLE, err_timeout=1 for one cycle, tx_data retained, rr_ptr already advanced.
  - tx_done in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter is built; err_timeout is tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
1. Reset, then req_valid=4'b0100 with req_data[23:16]=0xA5 → req_ready=4'b0100 same cycle; next cycle tx_start=1, tx_data=0xA5, grant_id=2; tx_done 20 cycles later → busy=0 the following cycle.
2. All four valid continuously with bytes 0x10,0x11,0x12,0x13, tx_done returned 5 cycles after each tx_start → tx_data sequence 0x10,0x11,0x12,0x13,0x10; grant_id 0,1,2,3,0.
3. rr_ptr=3 after a grant to requester 2, then req_valid=4'b0011 → requester 0 wins; rr_ptr becomes 1; requester 1 wins the next round.
4. rst asserted in WAIT_DONE with tx_data=0x7E → outputs zero immediately; after rst release with req_valid=4'b0010 → requester 1 granted (rr_ptr=0 scan).
5. tx_done pulse while in IDLE → no state change, no tx_start. tx_done coincident with START → back in IDLE the next cycle.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, tx_done withheld → err_timeout pulses exactly 16 cycles after tx_start, busy=0 the next cycle. Without the macro → busy stays 1 and err_timeout stays 0.
